// File: rtl/strobe_tagger_n.sv
// Multi-channel strobe timestamper: synchronises strobe inputs, tags rising edges
// and timer wraps with a free-running timestamp, and queues the records in a FIFO.
module strobe_tagger_n #(
   parameter int N_CH    = 4,
   parameter int TIME_W  = 36,
   parameter int FIFO_AW = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_CH-1:0]        strobe_in,
   input  logic [N_CH-1:0]        chan_enable,
   input  logic                   capture_operate,
   input  logic                   counter_reset,
   output logic [N_CH+TIME_W:0]   record_data,
   output logic                   record_valid,
   input  logic                   record_ready,
   output logic [TIME_W-1:0]      timer,
   output logic [15:0]            lost_count,
   output logic [FIFO_AW:0]       fifo_level
);

   localparam int REC_W = 1 + N_CH + TIME_W;
   localparam int DEPTH = 1 << FIFO_AW;

   localparam logic [TIME_W-1:0]  TIME_ONE = TIME_W'(1);
   localparam logic [TIME_W-1:0]  TIME_MAX = '1;
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

   logic [N_CH-1:0]    r_s1, r_s2, r_s3;
   logic [1:0]         r_arm;
   logic [TIME_W-1:0]  r_timer;
   logic               r_wrap;
   logic               r_rec_vld;
   logic [REC_W-1:0]   r_rec_data;
   logic               r_wr_en;
   logic [REC_W-1:0]   r_wr_data;
   logic [REC_W-1:0]   r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic [15:0]        r_lost;

   logic               w_armed;
   logic [N_CH-1:0]    w_edge;
   logic [N_CH-1:0]    w_mask;
   logic               w_rec_req;
   logic               w_empty, w_full;
   logic               w_push, w_pop, w_drop;

   // Edge detection stays disarmed until s3 holds real history, so a strobe
   // that is already high when reset releases is not mistaken for an edge.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep the s1->s2->s3 chain a true shift
      // register; blocking ones would collapse it into a single flop.
      if (!reset_n) begin
         r_s1  <= '0;
         r_s2  <= '0;
         r_s3  <= '0;
         r_arm <= '0;
      end else begin
         r_s1 <= strobe_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      end
   end

   assign w_armed   = (r_arm == 2'd3);
   assign w_edge    = r_s2 & ~r_s3 & {N_CH{w_armed}};
   assign w_mask    = w_edge & chan_enable;
   assign w_rec_req = capture_operate & ((|w_mask) | r_wrap);

   // r_wrap marks only the cycle whose zero came from rolling over.
   always_ff @(posedge clk) begin
      if (!reset_n || counter_reset) begin
         r_timer <= '0;
         r_wrap  <= 1'b0;
      end else if (capture_operate) begin
         r_timer <= r_timer + TIME_ONE;
         r_wrap  <= (r_timer == TIME_MAX);
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   // Record is formed in the detection cycle, then registered once more
   // ahead of the FIFO write port.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rec_vld  <= 1'b0;
         r_rec_data <= '0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= '0;
      end else begin
         r_rec_vld  <= w_rec_req;
         r_rec_data <= {r_wrap, w_mask, r_timer};
         r_wr_en    <= r_rec_vld;
         r_wr_data  <= r_rec_data;
      end
   end

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LVL_FULL);
   assign w_pop   = !w_empty && record_ready;
   assign w_push  = r_wr_en && !w_full;
   assign w_drop  = r_wr_en && w_full;

   // NOTE: the storage array has no reset; emptiness is tracked by r_count and
   // the output is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LVL_ONE;
            2'b01:   r_count <= r_count - LVL_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // A write into a full FIFO is lost even if the head pops in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n || counter_reset) begin
         r_lost <= '0;
      end else if (w_drop && (r_lost != 16'hFFFF)) begin
         r_lost <= r_lost + 16'd1;
      end
   end

   assign record_valid = !w_empty;
   assign record_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign timer        = r_timer;
   assign lost_count   = r_lost;
   assign fifo_level   = r_count;

endmodule

// File: tb/tb_strobe_tagger_n.sv
// Scoreboard bench for strobe_tagger_n: expected records are queued as strobes
// are driven and compared against the FIFO head whenever record_valid is high.
module tb_strobe_tagger_n;

   localparam int N_CH    = 4;
   localparam int TIME_W  = 8;
   localparam int FIFO_AW = 2;
   localparam int REC_W   = 1 + N_CH + TIME_W;

   logic               clk;
   logic               reset_n;
   logic [N_CH-1:0]    strobe_in;
   logic [N_CH-1:0]    chan_enable;
   logic               capture_operate;
   logic               counter_reset;
   logic [REC_W-1:0]   record_data;
   logic               record_valid;
   logic               record_ready;
   logic [TIME_W-1:0]  timer;
   logic [15:0]        lost_count;
   logic [FIFO_AW:0]   fifo_level;

   int n_vec = 0;
   int n_bad = 0;
   logic [REC_W-1:0] exp_q[$];
   logic [TIME_W-1:0] m_timer;

   strobe_tagger_n #(.N_CH(N_CH), .TIME_W(TIME_W), .FIFO_AW(FIFO_AW)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .strobe_in       (strobe_in),
      .chan_enable     (chan_enable),
      .capture_operate (capture_operate),
      .counter_reset   (counter_reset),
      .record_data     (record_data),
      .record_valid    (record_valid),
      .record_ready    (record_ready),
      .timer           (timer),
      .lost_count      (lost_count),
      .fifo_level      (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference timer: counts while capturing, cleared by either reset.
   always @(posedge clk) begin
      if (!reset_n || counter_reset) m_timer <= '0;
      else if (capture_operate)      m_timer <= m_timer + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Consumer side: the head must match the oldest expected record every cycle
   // it is presented, which also covers stability while stalled.
   always @(negedge clk) begin
      if (reset_n && record_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(record_valid), 32'd0);
         end else begin
            check("head_record", 32'(record_data), 32'(exp_q[0]));
            if (record_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_counters();
      counter_reset = 1'b1;
      tick(1);
      counter_reset = 1'b0;
   endtask

   // Raise strobes now; the edge is detected two edges later, when the timer
   // has advanced by two from its present value.
   task automatic fire(input logic [N_CH-1:0] bits, input bit keep, input int hi, input int lo);
      logic [TIME_W-1:0] ts;
      logic [N_CH-1:0]   mask;
      logic              wrap;
      ts   = m_timer + 8'd2;
      mask = bits & chan_enable;
      wrap = (ts == 8'd0);
      if (keep && capture_operate && ((mask != '0) || wrap))
         exp_q.push_back({wrap, mask, ts});
      strobe_in = bits;
      tick(hi);
      strobe_in = '0;
      tick(lo);
   endtask

   task automatic drain(input int budget);
      int i;
      record_ready = 1'b1;
      tick(5);
      i = 0;
      while ((exp_q.size() != 0 || record_valid) && i < budget) begin
         tick(1);
         i++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
      check("drain_valid", 32'(record_valid), 32'd0);
   endtask

   initial begin
      reset_n         = 1'b0;
      strobe_in       = '1;
      chan_enable     = '1;
      capture_operate = 1'b0;
      counter_reset   = 1'b0;
      record_ready    = 1'b0;
      tick(3);
      check("rst_timer", 32'(timer), 32'd0);
      check("rst_lost", 32'(lost_count), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_valid", 32'(record_valid), 32'd0);
      check("rst_data", 32'(record_data), 32'd0);

      // Release reset with strobes already high: no record may appear.
      reset_n         = 1'b1;
      capture_operate = 1'b1;
      tick(10);
      check("release_level", 32'(fifo_level), 32'd0);
      check("release_valid", 32'(record_valid), 32'd0);
      check("timer_run", 32'(timer), 32'(m_timer));
      strobe_in = '0;
      tick(3);

      // Single event at timer=10 and its latency.
      clear_counters();
      tick(10);
      check("timer_at_10", 32'(timer), 32'd10);
      exp_q.push_back({1'b0, 4'b0001, 8'd12});
      strobe_in = 4'b0001;
      tick(4);
      check("latency_3", 32'(record_valid), 32'd0);
      tick(1);
      check("latency_4", 32'(record_valid), 32'd1);
      check("single_rec", 32'(record_data), 32'({1'b0, 4'b0001, 8'd12}));
      strobe_in = '0;
      drain(20);

      // Channel merge and enable masking.
      clear_counters();
      chan_enable = 4'b1010;
      fire(4'b1010, 1'b1, 2, 2);
      chan_enable = 4'b0010;
      fire(4'b1010, 1'b1, 2, 2);
      chan_enable = 4'b0000;
      fire(4'b1010, 1'b1, 2, 2);
      chan_enable = 4'b1111;
      fire(4'b0101, 1'b1, 2, 2);
      fire(4'b1111, 1'b1, 2, 2);
      drain(20);

      // Capture off: no records, timer held.
      capture_operate = 1'b0;
      fire(4'b1111, 1'b1, 2, 2);
      tick(4);
      check("hold_level", 32'(fifo_level), 32'd0);
      check("hold_timer", 32'(timer), 32'(m_timer));
      capture_operate = 1'b1;
      drain(10);

      // Overflow: depth 4, six events, consumer stalled.
      record_ready = 1'b0;
      clear_counters();
      check("ovf_lost_start", 32'(lost_count), 32'd0);
      for (int i = 0; i < 6; i++)
         fire(4'(i + 1), (i < 4), 2, 2);
      tick(6);
      check("ovf_level", 32'(fifo_level), 32'd4);
      check("ovf_lost", 32'(lost_count), 32'd2);
      clear_counters();
      check("ovf_lost_clr", 32'(lost_count), 32'd0);
      check("ovf_no_flush", 32'(fifo_level), 32'd4);
      drain(30);

      // Backpressure: ready toggles every cycle while events stream in.
      clear_counters();
      fork
         begin
            for (int i = 0; i < 6; i++)
               fire(4'(8 - i), 1'b1, 1, 1);
         end
         begin
            for (int i = 0; i < 30; i++) begin
               record_ready = i[0];
               tick(1);
            end
         end
      join
      drain(30);
      check("bp_lost", 32'(lost_count), 32'd0);

      // Wrap alone, then a wrap coinciding with an edge.
      clear_counters();
      exp_q.push_back({1'b1, 4'b0000, 8'd0});
      tick(256);
      check("timer_wrapped", 32'(timer), 32'd0);
      tick(254);
      check("timer_254", 32'(timer), 32'd254);
      fire(4'b0100, 1'b1, 2, 2);
      drain(20);
      capture_operate = 1'b0;

      // Reset with three records queued.
      record_ready    = 1'b0;
      capture_operate = 1'b1;
      clear_counters();
      for (int i = 0; i < 3; i++)
         fire(4'b0001 << i, 1'b1, 2, 2);
      tick(6);
      check("pre_rst_level", 32'(fifo_level), 32'd3);
      reset_n      = 1'b0;
      record_ready = 1'b1;
      tick(1);
      check("mid_rst_valid", 32'(record_valid), 32'd0);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      check("mid_rst_timer", 32'(timer), 32'd0);
      check("mid_rst_lost", 32'(lost_count), 32'd0);
      exp_q.delete();
      reset_n = 1'b1;
      tick(8);
      check("post_rst_valid", 32'(record_valid), 32'd0);
      check("post_rst_level", 32'(fifo_level), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
